pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register. It is the generalised successor of the fixed-field inter-stage registers between IF/ID/EX/MEM/WB.
- Carries two bundles:
  - a control bundle, cleared to a bubble on flush or drain;
  - a data payload, which holds its value.
- Uses valid/ready handshake, flush, and a saturating stall-cycle counter.
- Instantiated once per stage boundary in the core pipeline.

Parameters:
- CTRL_W, 16: width of control bundle (write enables, wd_sel, sl_type, rd address); zeroed to a bubble.
- DATA_W, 96: width of payload (pc, alu_result, rD2 ...); never cleared except by reset.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage holds a live beat
- out_ready  in  1  downstream accepts beat
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0
- out_data  out  DATA_W  registered payload
- flush  in  1  kill stored and incoming beat (branch mispredict/trap)
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (async, rst=1): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid empty.
- Handshake:
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
  - Upstream must hold in_valid/in_ctrl/in_data stable until accepted.
- Base mode (no skid):
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - Latency 1 cycle.
  - Full throughput: one beat per cycle when out_ready=1.
- Per-edge priority:
  1. flush=1: out_valid<=0 and out_ctrl<=0. Any beat accepted that cycle is discarded. out_data holds.
  2. Else transfer in: out_valid<=1, out_ctrl<=in_ctrl, out_data<=in_data.
  3. Else transfer out: out_valid<=0, out_ctrl<=0 (bubble injection). out_data holds.
  4. Else hold.
- Simultaneous in and out transfer: new beat replaces old; out_valid stays 1.
- Flush does not gate in_ready. Upstream sees the beat consumed; the beat is dropped.
- stall_cnt:
  - +1 on each cycle with out_valid && !out_ready, including flush cycles.
  - Saturates at all-ones; no wrap.
  - Cleared only by reset.
- Reset asserted mid-transfer: beat lost; outputs take reset values immediately.

Optional Feature:
- Macro PIPE_STAGE_SKID_EN.
- Defined:
  - Adds one skid entry (ctrl+data) and a 3-state FSM: EMPTY, ONE, TWO.
  - in_ready is registered: in_ready = (state != TWO). No combinational out_ready->in_ready path.
  - Transitions:
    - EMPTY -in-> ONE.
    - ONE -in&!out-> TWO (beat to skid).
    - ONE -in&out-> ONE (main replaced).
    - ONE -out&!in-> EMPTY (bubble).
    - TWO -out-> ONE (skid moves to main; in_ready=0 in TWO, so no in).
    - Any state -flush-> EMPTY; both entries' ctrl zeroed.
  - Latency 1 cycle; full throughput; ordering preserved.
- Undefined: base mode only; no skid storage.

Decomposition:
- Shared package pipe_pkg:
  - typedef pipe_state_e {EMPTY, ONE, TWO};
  - CTRL_BUBBLE constant = '0;
  - per-stage ctrl struct typedefs (e.g. ex_mem_ctrl_t) packed to CTRL_W at instantiation.
- Natural sub-module: sat_counter (parametrised width, inc enable, saturate), used for stall_cnt.

Test Plan:
- Reset: rst=1 mid-run with out_valid=1 -> same cycle out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
- Streaming: out_ready=1, beats ctrl=0x0001..0x0005 on consecutive cycles -> appear 1 cycle later, one per cycle, in order; in_ready stays 1.
- Backpressure: beat ctrl=0x00A5/data=0x1234 held, out_ready=0 for 4 cycles -> out_valid=1, out holds 0x00A5/0x1234, stall_cnt=4, in_ready=0 (base); skid build: second beat accepted, then in_ready=0.
- Flush vs input: out_valid=1 with ctrl=0x00FF, flush=1 and in_valid=1 (ctrl=0x0011) same cycle -> next cycle out_valid=0, out_ctrl=0x0000; 0x0011 never emitted.
- Drain bubble: single beat ctrl=0x8001, out_ready=1, no further input -> out_ctrl=0x8001 for one cycle, then 0x0000 with out_valid=0; out_data unchanged.
- Saturation: STALL_CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage registers
package pipe_pkg;

    // Occupancy of a stage register when the skid entry is built in.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // A bubble is an all-zero control bundle; replicate this bit to CTRL_W.
    localparam logic CTRL_BUBBLE = 1'b0;

    // EX/MEM control bundle, packed to 16 bits to match the default CTRL_W.
    typedef struct packed {
        logic [3:0] rsvd;
        logic       reg_we;
        logic       mem_we;
        logic [1:0] wd_sel;
        logic [2:0] sl_type;
        logic [4:0] rd;
    } ex_mem_ctrl_t;

    // MEM/WB control bundle, packed to 16 bits.
    typedef struct packed {
        logic [7:0] rsvd;
        logic       reg_we;
        logic [1:0] wd_sel;
        logic [4:0] rd;
    } mem_wb_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with increment enable
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, clears the count
//   inc  - increment by one this cycle
//   cnt  - current count; sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and stall counter
//
// Optional skid entry enabled by defining PIPE_STAGE_SKID_EN.
//
// Ports:
//   clk, rst             - clock and asynchronous active-high reset
//   in_valid / in_ready  - upstream handshake
//   in_ctrl / in_data    - upstream control bundle and payload
//   out_valid / out_ready- downstream handshake
//   out_ctrl / out_data  - registered control (zero when not valid) and payload
//   flush                - discard stored and incoming beats
//   stall_cnt            - saturating count of cycles stalled by downstream
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W      = 16,
    parameter int DATA_W      = 96,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [CTRL_W-1:0] BUBBLE = {CTRL_W{CTRL_BUBBLE}};

    logic xfer_in;
    logic xfer_out;

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;

    // Flush cycles still count as stalled if downstream is not ready.
    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

`ifdef PIPE_STAGE_SKID_EN

    pipe_state_e         state_q;
    pipe_state_e         state_d;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic [DATA_W-1:0]   skid_data;

    // Both derive from the state register only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (xfer_in) state_d = ONE;
                ONE: begin
                    if (xfer_in && !xfer_out) begin
                        state_d = TWO;
                    end else if (!xfer_in && xfer_out) begin
                        state_d = EMPTY;
                    end
                end
                TWO:     if (xfer_out) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ctrl  <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            out_ctrl  <= BUBBLE;
            skid_ctrl <= BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
                    end else if (xfer_in) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (xfer_out) begin
                        out_ctrl <= BUBBLE;
                    end
                end
                TWO: begin
                    // Older beat leaves; the skid beat becomes the head.
                    if (xfer_out) begin
                        out_ctrl  <= skid_ctrl;
                        out_data  <= skid_data;
                        skid_ctrl <= BUBBLE;
                    end
                end
                default: out_ctrl <= BUBBLE;
            endcase
        end
    end

`else

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
        end else if (flush) begin
            // Upstream still sees its beat consumed; it is dropped here.
            out_valid <= 1'b0;
            out_ctrl  <= BUBBLE;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
            out_data  <= in_data;
        end else if (xfer_out) begin
            out_valid <= 1'b0;
            out_ctrl  <= BUBBLE;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ctrl;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ctrl;
    logic [95:0] out_data;
    logic        flush;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_ctrl;
    logic [95:0] s_out_data;
    logic [3:0]  s_stall_cnt;

    int n_cmp;
    int n_bad;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(
        .STALL_CNT_W (4)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_ctrl  (s_out_ctrl),
        .out_data  (s_out_data),
        .flush     (flush),
        .stall_cnt (s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 96'h0 || stall_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_init: valid=%b ctrl=%h data=%h stall=%0d required 0/0/0/0",
                     out_valid, out_ctrl, out_data, stall_cnt);
        end
        in_valid = 1'b1; in_ctrl = 16'h0033; in_data = 96'hABC;
        cyc();
        in_valid = 1'b0;
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h0033 || stall_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL reset_preload: valid=%b ctrl=%h stall=%0d required 1/0033/1",
                     out_valid, out_ctrl, stall_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 96'h0 || stall_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_async: valid=%b ctrl=%h data=%h stall=%0d required 0/0/0/0",
                     out_valid, out_ctrl, out_data, stall_cnt);
        end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 16'(i);
            in_data  = 96'(i * 256);
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_in_ready[%0d]: got %b required 1", i, in_ready);
            end
            cyc();
            n_cmp++;
            if (out_valid !== 1'b1 || out_ctrl !== 16'(i) || out_data !== 96'(i * 256)) begin
                n_bad++;
                $display("FAIL stream_beat[%0d]: valid=%b ctrl=%h data=%h required 1/%h/%h",
                         i, out_valid, out_ctrl, out_data, 16'(i), 96'(i * 256));
            end
        end
        in_valid = 1'b0;
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 96'h500) begin
            n_bad++;
            $display("FAIL stream_tail: valid=%b ctrl=%h data=%h required 0/0000/500",
                     out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; in_ctrl = 16'h00A5; in_data = 96'h1234;
        cyc();
        in_ctrl = 16'h00B6; in_data = 96'h5678;
        cyc();
`ifdef PIPE_STAGE_SKID_EN
        in_valid = 1'b0;
`endif
        for (int i = 0; i < 3; i++) cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h00A5 || out_data !== 96'h1234) begin
            n_bad++;
            $display("FAIL bp_hold: valid=%b ctrl=%h data=%h required 1/00a5/1234",
                     out_valid, out_ctrl, out_data);
        end
        n_cmp++;
        if (stall_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL bp_stall_cnt: got %0d required 4", stall_cnt);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_in_ready: got %b required 0", in_ready);
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h00B6 || out_data !== 96'h5678 || stall_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL bp_second: valid=%b ctrl=%h data=%h stall=%0d required 1/00b6/5678/4",
                     out_valid, out_ctrl, out_data, stall_cnt);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
            n_bad++;
            $display("FAIL bp_drain: valid=%b ctrl=%h required 0/0000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_ctrl = 16'h00FF; in_data = 96'hF0F0;
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h00FF) begin
            n_bad++;
            $display("FAIL flush_pre: valid=%b ctrl=%h required 1/00ff", out_valid, out_ctrl);
        end
        in_ctrl = 16'h0011; in_data = 96'h1111;
        flush = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_in_ready: got %b required 1", in_ready);
        end
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 96'hF0F0) begin
            n_bad++;
            $display("FAIL flush_kill: valid=%b ctrl=%h data=%h required 0/0000/f0f0",
                     out_valid, out_ctrl, out_data);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
            n_bad++;
            $display("FAIL flush_no_emit: valid=%b ctrl=%h required 0/0000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_drain();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 16'h8001; in_data = 96'hDEAD;
        cyc();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 16'h8001 || out_data !== 96'hDEAD) begin
            n_bad++;
            $display("FAIL drain_beat: valid=%b ctrl=%h data=%h required 1/8001/dead",
                     out_valid, out_ctrl, out_data);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 96'hDEAD) begin
            n_bad++;
            $display("FAIL drain_bubble: valid=%b ctrl=%h data=%h required 0/0000/dead",
                     out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_ctrl = 16'h0042; in_data = 96'h42;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        n_cmp++;
        if (s_stall_cnt !== 4'd10) begin
            n_bad++;
            $display("FAIL sat_mid: got %0d required 10", s_stall_cnt);
        end
        for (int i = 0; i < 10; i++) cyc();
        n_cmp++;
        if (s_stall_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_hold: got %0d required 15", s_stall_cnt);
        end
        n_cmp++;
        if (stall_cnt !== 16'd20) begin
            n_bad++;
            $display("FAIL sat_wide: got %0d required 20", stall_cnt);
        end
        out_ready = 1'b1;
        cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_drain();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
